// File: rtl/trace_retire_if.sv
// Retirement-in / trace-out bundle of the retire buffer.
// master: pipeline + tracer side, slave: the buffer itself.
interface trace_retire_if #(
    parameter int CNT_W = 16
);
    logic             trace_en;
    logic             ret_valid;
    logic [31:0]      ret_pc;
    logic [31:0]      ret_insn;
    logic [4:0]       ret_rd_addr;
    logic [31:0]      ret_rd_wdata;
    logic             trc_valid;
    logic             trc_ready;
    logic [31:0]      trc_pc;
    logic [31:0]      trc_insn;
    logic [4:0]       trc_rd_addr;
    logic [31:0]      trc_rd_wdata;
    logic [31:0]      trc_cycle;
    logic [2:0]       trc_class;
    logic [63:0]      instret;
    logic [CNT_W-1:0] drop_cnt;
    logic             overflow;

    modport master (
        output trace_en, ret_valid, ret_pc, ret_insn, ret_rd_addr, ret_rd_wdata, trc_ready,
        input  trc_valid, trc_pc, trc_insn, trc_rd_addr, trc_rd_wdata, trc_cycle, trc_class,
               instret, drop_cnt, overflow
    );

    modport slave (
        input  trace_en, ret_valid, ret_pc, ret_insn, ret_rd_addr, ret_rd_wdata, trc_ready,
        output trc_valid, trc_pc, trc_insn, trc_rd_addr, trc_rd_wdata, trc_cycle, trc_class,
               instret, drop_cnt, overflow
    );
endinterface

// File: rtl/trace_retire_buffer.sv
// Retirement capture FIFO feeding the instruction tracer.
// Stamps each retirement with a free-running cycle count, classifies the
// opcode, and buffers it; a full FIFO drops and counts rather than stalling.
// The head entry lives in dedicated output registers so the tracer sees
// registered data (first-word fall-through, one cycle after push-to-empty).
module trace_retire_buffer #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input logic          clk,
    input logic          rst,
    trace_retire_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [31:0] cycle;
        logic [2:0]  cls;
    } entry_t;

    localparam logic [2:0] CLS_ALU    = 3'd0;
    localparam logic [2:0] CLS_BRANCH = 3'd1;
    localparam logic [2:0] CLS_JUMP   = 3'd2;
    localparam logic [2:0] CLS_LOAD   = 3'd3;
    localparam logic [2:0] CLS_STORE  = 3'd4;
    localparam logic [2:0] CLS_SYSTEM = 3'd5;
    localparam logic [2:0] CLS_UNK    = 3'd7;

    entry_t           mem [DEPTH];
    entry_t           head;
    entry_t           new_e;
    logic             head_vld;
    logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_ptr_n;
    logic [PTR_W:0]   count, count_n;
    logic [31:0]      cyc;
    logic [63:0]      instret;
    logic [CNT_W-1:0] drop_cnt;
    logic             overflow;
    logic             push, pop, drop;

    // RV32 opcode classifier: opcode plus funct3 wildcard match, exact
    // match for the fixed-encoding privileged instructions.
    function automatic logic [2:0] classify(input logic [31:0] insn);
        logic [6:0] op;
        logic [2:0] f3;
        logic [2:0] c;
        op = insn[6:0];
        f3 = insn[14:12];
        c  = CLS_UNK;
        case (op)
            7'b0110111, 7'b0010111, 7'b0110011, 7'b0010011: c = CLS_ALU;
            7'b1100011: if (f3 != 3'b010 && f3 != 3'b011) c = CLS_BRANCH;
            7'b1101111: c = CLS_JUMP;
            7'b1100111: if (f3 == 3'b000) c = CLS_JUMP;
            7'b0000011: if (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) c = CLS_LOAD;
            7'b0100011: if (f3 inside {3'b000, 3'b001, 3'b010}) c = CLS_STORE;
            7'b0001111: if (f3 inside {3'b000, 3'b001}) c = CLS_SYSTEM;
            7'b1110011: begin
                if (f3 == 3'b000) begin
                    if (insn inside {32'h00000073, 32'h00100073, 32'h30200073, 32'h10500073})
                        c = CLS_SYSTEM;
                end else if (f3 != 3'b100) begin
                    c = CLS_SYSTEM;
                end
            end
            default: c = CLS_UNK;
        endcase
        return c;
    endfunction

    // Handshake decode and next-state pointers/occupancy.
    always_comb begin
        pop      = head_vld && bus.trc_ready;
        push     = bus.ret_valid && bus.trace_en && (count != FULL || pop);
        drop     = bus.ret_valid && bus.trace_en && count == FULL && !pop;
        rd_ptr_n = rd_ptr + {{(PTR_W-1){1'b0}}, pop};
        count_n  = count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    end

    // Entry assembled from the WB-stage retirement.
    always_comb begin
        new_e          = '0;
        new_e.pc       = bus.ret_pc;
        new_e.insn     = bus.ret_insn;
        new_e.rd_addr  = bus.ret_rd_addr;
        new_e.rd_wdata = (bus.ret_rd_addr == 5'd0) ? 32'd0 : bus.ret_rd_wdata;
        new_e.cycle    = cyc;
        new_e.cls      = classify(bus.ret_insn);
    end

    // Free-running cycle stamp, retired-instruction count and drop stats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc      <= '0;
            instret  <= '0;
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            cyc <= cyc + 32'd1;
            if (bus.ret_valid) instret <= instret + 64'd1;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
            rd_ptr <= rd_ptr_n;
            count  <= count_n;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= new_e;
    end

    // Head register: reloads only when the head changes (pop, or first
    // entry into an empty FIFO) so data stays stable under back-pressure.
    // A push landing in the new head slot is bypassed from the input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head     <= '0;
            head_vld <= 1'b0;
        end else begin
            head_vld <= (count_n != '0);
            if (count_n != '0 && (pop || count == '0))
                head <= (push && wr_ptr == rd_ptr_n) ? new_e : mem[rd_ptr_n];
        end
    end

    assign bus.trc_valid    = head_vld;
    assign bus.trc_pc       = head.pc;
    assign bus.trc_insn     = head.insn;
    assign bus.trc_rd_addr  = head.rd_addr;
    assign bus.trc_rd_wdata = head.rd_wdata;
    assign bus.trc_cycle    = head.cycle;
    assign bus.trc_class    = head.cls;
    assign bus.instret      = instret;
    assign bus.drop_cnt     = drop_cnt;
    assign bus.overflow     = overflow;
endmodule

// File: tb/tb_trace_retire_buffer.sv
// Directed bench for trace_retire_buffer: main instance (DEPTH 8, CNT_W 16)
// plus a CNT_W=4 instance for drop-counter saturation.
module tb_trace_retire_buffer;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   tb_cyc;

    trace_retire_if #(.CNT_W(16)) bus ();
    trace_retire_if #(.CNT_W(4))  sbus ();

    trace_retire_buffer #(.DEPTH(8), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
    trace_retire_buffer #(.DEPTH(8), .CNT_W(4))  u_sat (.clk(clk), .rst(rst), .bus(sbus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference cycle counter: value during the current cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) tb_cyc <= 0;
        else     tb_cyc <= tb_cyc + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_ret(input logic [31:0] pc, input logic [31:0] insn,
                             input logic [4:0] rd, input logic [31:0] wd);
        bus.ret_valid    = 1'b1;
        bus.ret_pc       = pc;
        bus.ret_insn     = insn;
        bus.ret_rd_addr  = rd;
        bus.ret_rd_wdata = wd;
    endtask

    logic [31:0] sw_insn [7];
    logic [2:0]  sw_cls  [7];
    logic [4:0]  sw_rd   [7];
    logic [31:0] sw_wd   [7];
    logic [31:0] sw_exp  [7];

    initial begin
        int base;
        int n;
        logic [31:0] last_pc;

        sw_insn = '{32'h00000063, 32'h0000006F, 32'h00002003, 32'h00002023,
                    32'h00000073, 32'h0000007F, 32'h00000013};
        sw_cls  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7, 3'd0};
        sw_rd   = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd0};
        sw_wd   = '{32'h11, 32'h12, 32'h13, 32'h14, 32'h15, 32'h16, 32'hDEAD};
        sw_exp  = '{32'h11, 32'h12, 32'h13, 32'h14, 32'h15, 32'h16, 32'h0};

        rst = 1'b1;
        bus.trace_en = 1'b1; bus.ret_valid = 1'b0; bus.trc_ready = 1'b0;
        bus.ret_pc = '0; bus.ret_insn = '0; bus.ret_rd_addr = '0; bus.ret_rd_wdata = '0;
        sbus.trace_en = 1'b1; sbus.ret_valid = 1'b0; sbus.trc_ready = 1'b0;
        sbus.ret_pc = 32'h800; sbus.ret_insn = 32'h00000013; sbus.ret_rd_addr = 5'd1;
        sbus.ret_rd_wdata = 32'h1;

        repeat (2) @(negedge clk);
        chk("rst_valid",    64'(bus.trc_valid), 64'd0);
        chk("rst_instret",  bus.instret, 64'd0);
        chk("rst_drop",     64'(bus.drop_cnt), 64'd0);
        chk("rst_overflow", 64'(bus.overflow), 64'd0);
        chk("rst_pc",       64'(bus.trc_pc), 64'd0);

        // Single retire pushed in cycle 3.
        rst = 1'b0;
        step(); step(); step();
        drive_ret(32'h100, 32'h00700293, 5'd5, 32'd7);
        step();
        bus.ret_valid = 1'b0;
        chk("single_valid",  64'(bus.trc_valid), 64'd1);
        chk("single_class",  64'(bus.trc_class), 64'd0);
        chk("single_cycle",  64'(bus.trc_cycle), 64'd3);
        chk("single_wdata",  64'(bus.trc_rd_wdata), 64'd7);
        chk("single_pc",     64'(bus.trc_pc), 64'h100);
        chk("single_instret", bus.instret, 64'd1);
        step();
        chk("hold_valid", 64'(bus.trc_valid), 64'd1);
        chk("hold_pc",    64'(bus.trc_pc), 64'h100);
        bus.trc_ready = 1'b1;
        step();
        bus.trc_ready = 1'b0;
        chk("single_popped", 64'(bus.trc_valid), 64'd0);

        // Classification sweep, one entry in flight at a time.
        for (int i = 0; i < 7; i++) begin
            drive_ret(32'h180 + 32'(i * 4), sw_insn[i], sw_rd[i], sw_wd[i]);
            step();
            bus.ret_valid = 1'b0;
            chk($sformatf("class_%0d", i), 64'(bus.trc_class), 64'(sw_cls[i]));
            chk($sformatf("wdata_%0d", i), 64'(bus.trc_rd_wdata), 64'(sw_exp[i]));
            bus.trc_ready = 1'b1;
            step();
            bus.trc_ready = 1'b0;
        end
        chk("sweep_instret", bus.instret, 64'd8);
        chk("sweep_empty",   64'(bus.trc_valid), 64'd0);

        // Fill with back-pressure: 10 retires, 2 dropped.
        base = tb_cyc;
        for (int i = 0; i < 10; i++) begin
            drive_ret(32'h200 + 32'(i * 4), 32'h00100093, 5'd1, 32'(i));
            step();
        end
        bus.ret_valid = 1'b0;
        chk("fill_drop",     64'(bus.drop_cnt), 64'd2);
        chk("fill_overflow", 64'(bus.overflow), 64'd1);
        chk("fill_instret",  bus.instret, 64'd18);
        chk("fill_head_pc",  64'(bus.trc_pc), 64'h200);
        bus.trc_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain_valid_%0d", i), 64'(bus.trc_valid), 64'd1);
            chk($sformatf("drain_pc_%0d", i),    64'(bus.trc_pc), 64'(32'h200 + 32'(i * 4)));
            chk($sformatf("drain_cyc_%0d", i),   64'(bus.trc_cycle), 64'(base + i));
            step();
        end
        bus.trc_ready = 1'b0;
        chk("drain_empty", 64'(bus.trc_valid), 64'd0);

        // Full FIFO with simultaneous push and pop.
        for (int i = 0; i < 8; i++) begin
            drive_ret(32'h400 + 32'(i * 4), 32'h00100093, 5'd1, 32'(i));
            step();
        end
        drive_ret(32'h500, 32'h00100093, 5'd1, 32'h55);
        bus.trc_ready = 1'b1;
        step();
        bus.ret_valid = 1'b0;
        chk("full_pp_drop",  64'(bus.drop_cnt), 64'd2);
        chk("full_pp_valid", 64'(bus.trc_valid), 64'd1);
        chk("full_pp_head",  64'(bus.trc_pc), 64'h404);
        n = 0;
        last_pc = '0;
        for (int t = 0; t < 20 && bus.trc_valid; t++) begin
            last_pc = bus.trc_pc;
            step();
            n++;
        end
        bus.trc_ready = 1'b0;
        chk("full_pp_count", 64'(n), 64'd8);
        chk("full_pp_last",  64'(last_pc), 64'h500);
        chk("full_pp_instret", bus.instret, 64'd27);

        // trace_en=0 after a fresh reset.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.trace_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_ret(32'h700 + 32'(i * 4), 32'h00100093, 5'd1, 32'(i));
            step();
        end
        bus.ret_valid = 1'b0;
        bus.trace_en = 1'b1;
        chk("dis_valid",   64'(bus.trc_valid), 64'd0);
        chk("dis_drop",    64'(bus.drop_cnt), 64'd0);
        chk("dis_instret", bus.instret, 64'd4);
        chk("dis_overflow", 64'(bus.overflow), 64'd0);

        // Drop saturation on the 4-bit counter instance.
        sbus.ret_valid = 1'b1;
        repeat (22) step();
        chk("sat_drop_14", 64'(sbus.drop_cnt), 64'd14);
        repeat (6) step();
        sbus.ret_valid = 1'b0;
        chk("sat_drop_15",  64'(sbus.drop_cnt), 64'd15);
        chk("sat_overflow", 64'(sbus.overflow), 64'd1);
        chk("sat_instret",  sbus.instret, 64'd28);

        // Async reset mid-cycle with 5 entries buffered.
        for (int i = 0; i < 5; i++) begin
            drive_ret(32'h900 + 32'(i * 4), 32'h00100093, 5'd1, 32'(i));
            step();
        end
        bus.ret_valid = 1'b0;
        chk("pre_rst_valid", 64'(bus.trc_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid",    64'(bus.trc_valid), 64'd0);
        chk("arst_instret",  bus.instret, 64'd0);
        chk("arst_pc",       64'(bus.trc_pc), 64'd0);
        chk("arst_overflow", 64'(sbus.overflow), 64'd0);
        chk("arst_drop",     64'(sbus.drop_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        drive_ret(32'h600, 32'h00000063, 5'd0, 32'h0);
        step();
        bus.ret_valid = 1'b0;
        chk("post_rst_valid", 64'(bus.trc_valid), 64'd1);
        chk("post_rst_cycle", 64'(bus.trc_cycle), 64'd0);
        chk("post_rst_pc",    64'(bus.trc_pc), 64'h600);
        chk("post_rst_class", 64'(bus.trc_class), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
